// File: rtl/uart_parity_pkg.sv
// Parity-type codes and mode constants shared by the parity engine and the TX/RX framers.
// Mark/space codes are only meaningful when UART_PARITY_MARK_SPACE_EN is defined.
package uart_parity_pkg;

    localparam logic [2:0] PAR_NONE0 = 3'b000;
    localparam logic [2:0] PAR_ODD   = 3'b001;
    localparam logic [2:0] PAR_EVEN  = 3'b010;
    localparam logic [2:0] PAR_NONE1 = 3'b011;
    localparam logic [2:0] PAR_MARK  = 3'b100;
    localparam logic [2:0] PAR_SPACE = 3'b101;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/uart_parity_engine_if.sv
// Beat-level bus of the parity engine: input beat from the frame buffer, output beat to the shifter.
// A beat moves on a side when its valid and ready are both high at the rising clock edge;
// valid and its payload stay stable until accepted.
interface uart_parity_engine_if #(
    parameter int DATA_W = 8
);
    logic [2:0]        parity_type;
    logic              chk_mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_parity;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_parity;
    logic              out_perr;

    modport master (
        output parity_type, chk_mode, in_valid, in_data, in_parity, out_ready,
        input  in_ready, out_valid, out_data, out_parity, out_perr
    );

    modport slave (
        input  parity_type, chk_mode, in_valid, in_data, in_parity, out_ready,
        output in_ready, out_valid, out_data, out_parity, out_perr
    );
endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity bit for one character, plus a flag saying whether the type is checkable.
// Mark/space support is built only when UART_PARITY_MARK_SPACE_EN is defined.
module uart_parity_calc
    import uart_parity_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [2:0]        parity_type_i,
    output logic              par_bit_o,
    output logic              par_chk_o
);
    logic red_xor;

    assign red_xor = ^data_i;

    // "None" types drive the line idle level and are never checked.
    always_comb begin
        par_bit_o = 1'b1;
        par_chk_o = 1'b0;
        case (parity_type_i)
            PAR_ODD: begin
                par_bit_o = ~red_xor;
                par_chk_o = 1'b1;
            end
            PAR_EVEN: begin
                par_bit_o = red_xor;
                par_chk_o = 1'b1;
            end
`ifdef UART_PARITY_MARK_SPACE_EN
            PAR_MARK: begin
                par_bit_o = 1'b1;
                par_chk_o = 1'b1;
            end
            PAR_SPACE: begin
                par_bit_o = 1'b0;
                par_chk_o = 1'b1;
            end
`endif
            default: begin
                par_bit_o = 1'b1;
                par_chk_o = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/uart_parity_engine.sv
// UART parity generator/checker: one handshake register stage plus a saturating error counter.
// Optional mark/space parity via UART_PARITY_MARK_SPACE_EN (implemented in uart_parity_calc).
module uart_parity_engine
    import uart_parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    uart_parity_engine_if.slave  bus,
    input  logic                 clr_err,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 err_sticky
);
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_parity_q, out_parity_d;
    logic              out_perr_q, out_perr_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_sticky_q, err_sticky_d;

    logic in_ready;
    logic accept;
    logic calc_bit;
    logic calc_chk;
    logic beat_perr;
    logic err_inc;

    uart_parity_calc #(.DATA_W(DATA_W)) u_calc (
        .data_i        (bus.in_data),
        .parity_type_i (bus.parity_type),
        .par_bit_o     (calc_bit),
        .par_chk_o     (calc_chk)
    );

    assign in_ready  = reset_n & (~out_valid_q | bus.out_ready);
    assign accept    = bus.in_valid & in_ready;
    assign beat_perr = (bus.chk_mode == MODE_CHK) & calc_chk & (bus.in_parity != calc_bit);
    // Gating with accept keeps X on idle in_data away from the error state.
    assign err_inc   = accept & beat_perr;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_parity_d = out_parity_q;
        out_perr_d   = out_perr_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = bus.in_data;
            out_parity_d = (bus.chk_mode == MODE_CHK) ? bus.in_parity : calc_bit;
            out_perr_d   = beat_perr;
        end else if (bus.out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // A new error in the clearing cycle survives the clear.
    always_comb begin
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (clr_err) begin
            err_cnt_d    = err_inc ? CNT_W'(1) : '0;
            err_sticky_d = err_inc;
        end else if (err_inc) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_parity_q <= 1'b1;
            out_perr_q   <= 1'b0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_parity_q <= out_parity_d;
            out_perr_q   <= out_perr_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_parity = out_parity_q;
    assign bus.out_perr   = out_perr_q;
    assign err_cnt        = err_cnt_q;
    assign err_sticky     = err_sticky_q;
endmodule

// File: tb/tb_uart_parity_engine.sv
// Bench for uart_parity_engine: directed spec cases plus a randomized handshake stream
// checked against a queue-based reference model (both macro builds handled).
module tb_uart_parity_engine;
    import uart_parity_pkg::*;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             clr_err = 1'b0;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sticky;

    uart_parity_engine_if #(.DATA_W(DATA_W)) bus();

    uart_parity_engine #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .clr_err    (clr_err),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard: beats accepted but not yet delivered, packed {data, parity, perr}.
    logic [DATA_W+1:0] exp_q[$];
    int   exp_cnt = 0;
    logic exp_sticky = 1'b0;

    function automatic logic ref_bit(logic [DATA_W-1:0] d, logic [2:0] t);
        int ones = 0;
        for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
        case (t)
            3'd1: return (ones % 2) == 0;
            3'd2: return (ones % 2) == 1;
`ifdef UART_PARITY_MARK_SPACE_EN
            3'd4: return 1'b1;
            3'd5: return 1'b0;
`endif
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic ref_checked(logic [2:0] t);
`ifdef UART_PARITY_MARK_SPACE_EN
        return (t == 3'd1) || (t == 3'd2) || (t == 3'd4) || (t == 3'd5);
`else
        return (t == 3'd1) || (t == 3'd2);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle from just after a falling edge, returns at the next falling edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [2:0] t,
                        input logic m, input logic p, input logic rdy, input logic clr,
                        output logic acc);
        logic exp_rdy, deliv, e, b;
        bus.in_valid    = v;
        bus.in_data     = d;
        bus.parity_type = t;
        bus.chk_mode    = m;
        bus.in_parity   = p;
        bus.out_ready   = rdy;
        clr_err         = clr;
        #1;
        exp_rdy = (exp_q.size() == 0) || rdy;
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        acc   = v && exp_rdy;
        deliv = (exp_q.size() != 0) && rdy;
        @(posedge clk);
        if (deliv) void'(exp_q.pop_front());
        e = 1'b0;
        if (acc) begin
            b = ref_bit(d, t);
            e = m && ref_checked(t) && (p != b);
            exp_q.push_back({d, (m ? p : b), e});
        end
        if (clr) begin
            exp_cnt    = e ? 1 : 0;
            exp_sticky = e;
        end else if (e) begin
            if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
            exp_sticky = 1'b1;
        end
        @(negedge clk);
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("out_data",   {24'd0, bus.out_data},   {24'd0, exp_q[0][DATA_W+1:2]});
            check("out_parity", {31'd0, bus.out_parity}, {31'd0, exp_q[0][1]});
            check("out_perr",   {31'd0, bus.out_perr},   {31'd0, exp_q[0][0]});
        end
        check("err_cnt",    {24'd0, err_cnt},    exp_cnt);
        check("err_sticky", {31'd0, err_sticky}, {31'd0, exp_sticky});
        bus.in_valid = 1'b0;
        clr_err      = 1'b0;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        clr_err      = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        exp_cnt    = 0;
        exp_sticky = 1'b0;
        check("rst_out_valid",  {31'd0, bus.out_valid},  32'd0);
        check("rst_out_data",   {24'd0, bus.out_data},   32'd0);
        check("rst_out_parity", {31'd0, bus.out_parity}, 32'd1);
        check("rst_out_perr",   {31'd0, bus.out_perr},   32'd0);
        check("rst_err_cnt",    {24'd0, err_cnt},        32'd0);
        check("rst_err_sticky", {31'd0, err_sticky},     32'd0);
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    logic             acc;
    logic             hold;
    logic             rv, rm, rp, rr, rc;
    logic [DATA_W-1:0] rd;
    logic [2:0]       rt;

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.parity_type = PAR_NONE0;
        bus.chk_mode    = MODE_GEN;
        bus.in_parity   = 1'b0;
        bus.out_ready   = 1'b1;
        @(negedge clk);
        do_reset();

        // Generate mode reference values
        step(1'b1, 8'h96, PAR_EVEN, MODE_GEN, 1'b0, 1'b1, 1'b0, acc);
        check("gen_even_96", {31'd0, bus.out_parity}, 32'd0);
        step(1'b1, 8'h96, PAR_ODD, MODE_GEN, 1'b0, 1'b1, 1'b0, acc);
        check("gen_odd_96", {31'd0, bus.out_parity}, 32'd1);
        step(1'b1, 8'h07, PAR_EVEN, MODE_GEN, 1'b0, 1'b1, 1'b0, acc);
        check("gen_even_07", {31'd0, bus.out_parity}, 32'd1);
        step(1'b1, 8'h5A, PAR_NONE1, MODE_GEN, 1'b0, 1'b1, 1'b0, acc);
        check("gen_none", {31'd0, bus.out_parity}, 32'd1);

        // Check mode
        step(1'b1, 8'h07, PAR_ODD, MODE_CHK, 1'b1, 1'b1, 1'b0, acc);
        check("chk_perr_set", {31'd0, bus.out_perr}, 32'd1);
        check("chk_cnt_one",  {24'd0, err_cnt}, 32'd1);
        check("chk_sticky",   {31'd0, err_sticky}, 32'd1);
        step(1'b1, 8'h07, PAR_ODD, MODE_CHK, 1'b0, 1'b1, 1'b0, acc);
        check("chk_perr_clr", {31'd0, bus.out_perr}, 32'd0);
        check("chk_cnt_hold", {24'd0, err_cnt}, 32'd1);

        // X on idle data must not disturb the error state
        step(1'b0, 8'hxx, PAR_ODD, MODE_CHK, 1'b1, 1'b1, 1'b0, acc);
        check("x_idle_cnt", {24'd0, err_cnt}, 32'd1);

        // Back-pressure: A held for 3 cycles while B is offered
        step(1'b1, 8'h5A, PAR_EVEN, MODE_GEN, 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'hC3, PAR_ODD, MODE_GEN, 1'b0, 1'b0, 1'b0, acc);
            check("bp_hold_data", {24'd0, bus.out_data}, 32'h5A);
            check("bp_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        end
        step(1'b1, 8'hC3, PAR_ODD, MODE_GEN, 1'b0, 1'b1, 1'b0, acc);
        check("bp_second_data", {24'd0, bus.out_data}, 32'hC3);
        step(1'b0, 8'h00, PAR_ODD, MODE_GEN, 1'b0, 1'b1, 1'b0, acc);
        check("bp_drained", {31'd0, bus.out_valid}, 32'd0);

        // Random stream with random back-pressure and occasional clears
        hold = 1'b0;
        rv = 1'b0; rd = '0; rt = '0; rm = 1'b0; rp = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!hold) begin
                rv = ($urandom_range(0, 3) != 0);
                rd = DATA_W'($urandom);
                rt = 3'($urandom_range(0, 7));
                rm = 1'($urandom_range(0, 1));
                rp = 1'($urandom_range(0, 1));
            end
            rr = ($urandom_range(0, 2) != 0);
            rc = ($urandom_range(0, 15) == 0);
            step(rv, rd, rt, rm, rp, rr, rc, acc);
            hold = rv && !acc;
        end

        // Saturation: 300 erroring beats back to back
        for (int i = 0; i < 300; i++) begin
            rd = DATA_W'($urandom);
            step(1'b1, rd, PAR_ODD, MODE_CHK, ~ref_bit(rd, PAR_ODD), 1'b1, 1'b0, acc);
        end
        check("sat_cnt", {24'd0, err_cnt}, 32'hFF);
        step(1'b1, 8'h07, PAR_EVEN, MODE_CHK, 1'b0, 1'b1, 1'b1, acc);
        check("clr_with_err_cnt",    {24'd0, err_cnt},    32'd1);
        check("clr_with_err_sticky", {31'd0, err_sticky}, 32'd1);
        step(1'b0, 8'h00, PAR_EVEN, MODE_CHK, 1'b0, 1'b1, 1'b1, acc);
        check("clr_cnt",    {24'd0, err_cnt},    32'd0);
        check("clr_sticky", {31'd0, err_sticky}, 32'd0);

        // Mark / space codes
        step(1'b1, 8'h00, PAR_MARK, MODE_GEN, 1'b0, 1'b1, 1'b0, acc);
        check("mark_gen", {31'd0, bus.out_parity}, 32'd1);
        step(1'b1, 8'h00, PAR_SPACE, MODE_CHK, 1'b1, 1'b1, 1'b0, acc);
`ifdef UART_PARITY_MARK_SPACE_EN
        check("space_chk_perr", {31'd0, bus.out_perr}, 32'd1);
`else
        check("space_chk_perr", {31'd0, bus.out_perr}, 32'd0);
`endif

        // Reset with a beat stalled in the stage: it must never be delivered
        step(1'b1, 8'h33, PAR_EVEN, MODE_GEN, 1'b0, 1'b0, 1'b0, acc);
        check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        do_reset();
        step(1'b0, 8'h00, PAR_EVEN, MODE_GEN, 1'b0, 1'b1, 1'b0, acc);
        check("discarded_beat", {31'd0, bus.out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
